mem_access_tracer: RTL
======================

// Module: mem_access_tracer
// PURPOSE
//  Synthesizable, parametrised data-memory access tracer for the MIPS datapath. Samples the
//  DataMem bus (addr/wdata/rdata/read/write) on each rising edge of the access strobe `pulse`.
//  Filters by address window and pushes {kind, addr, data, timestamp} records into a ring buffer.
//  The buffer is drained over a valid/ready port (UART/debug peripheral); replaces $display tracing.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  DEPTH    16  trace entries; power of 2, >=2
//  TS_W     16  timestamp width (clk cycles since reset, wraps)
//  DROP_W   8   dropped-record counter width (saturating)
// PORTS
//  clk        in   1              system clock
//  reset      in   1              synchronous, active-high reset
//  addr       in   ADDR_W         DataMem address
//  wdata      in   DATA_W         DataMem write data
//  rdata      in   DATA_W         DataMem read data
//  read       in   1              DataMem read enable
//  write      in   1              DataMem write enable
//  pulse      in   1              access strobe (level, sampled on clk)
//  enable     in   1              capture enable (level)
//  wrap_mode  in   1              0=stop when full (drop new), 1=overwrite oldest
//  clear      in   1              sync flush of buffer and status
//  win_lo     in   ADDR_W         address filter low bound (inclusive)
//  win_hi     in   ADDR_W         address filter high bound (inclusive)
//  out_valid  out  1              head record available
//  out_ready  in   1              consumer accepts head
//  out_kind   out  2              01=read, 10=write, 11=read+write
//  out_addr   out  ADDR_W         head record address
//  out_data   out  DATA_W         wdata if write bit set, else rdata
//  out_ts     out  TS_W           timestamp of capture
//  count      out  $clog2(DEPTH)+1  records held, 0..DEPTH
//  overflow   out  1              sticky: a record was overwritten (wrap_mode)
//  dropped    out  DROP_W         records discarded (stop mode), saturates at all-ones
// BEHAVIOUR
//  - Reset: ptrs=0, count=0, out_valid=0, overflow=0, dropped=0, ts=0, pulse_q=1.
//    out_kind/addr/data/ts=0 while empty. pulse_q=1 means a pulse held high across reset never captures.
//  - Edge detect: ev = pulse & ~pulse_q; pulse_q <= pulse every cycle.
//  - Capture condition: ev & enable & (read|write) & win_lo<=addr<=win_hi (unsigned).
//    win_lo>win_hi filters everything.
//  - Record contents:
//    - kind = {write,read}
//    - data = write ? wdata : rdata
//    - ts = timestamp counter value in the capture cycle
//    - Bus sampled in the same cycle as ev.
//  - Latency: the record is visible on out_* the cycle after capture (out_valid rises then).
//  - out_* are driven from the head entry and stay stable while out_valid & ~out_ready.
//    Pop on out_valid & out_ready.
//  - Not full, capture and pop in the same cycle: both occur, count unchanged.
//  - Full, stop mode: capture without pop -> record dropped, dropped++ (saturating).
//    Capture with pop -> accepted, count stays DEPTH.
//  - Full, wrap mode: capture -> written at wr ptr, rd ptr +1, overflow<=1, count stays DEPTH.
//    With a simultaneous pop the rd ptr advances once only; the popped record is the old head.
//  - Pointers wrap modulo DEPTH; count is DEPTH+1-valued, so full and empty are distinct.
//  - clear: same as reset except ts keeps counting; clear beats a same-cycle capture/pop.
//  - reset mid-drain: the buffer is emptied; out_valid is 0 in the next cycle.
//  - wrap_mode/enable/window changes take effect in the cycle they are sampled; no stored records change.
// STRUCTURE
//  - Package mem_trace_pkg:
//    - KIND_RD/KIND_WR/KIND_RW localparams
//    - record field offsets and total record width REC_W = 2+ADDR_W+DATA_W+TS_W
//  - Sub-module trace_ring_fifo #(WIDTH=REC_W, DEPTH):
//    - ptrs, count, full/empty, overwrite-on-push option
//    - combinational head read
//  - Top level: edge detect, filter, ts counter, dropped/overflow logic.
// TESTING (DEPTH=4 unless noted)
//  1 Single read addr=0x10,rdata=0xAB, pulse high 3 cycles -> exactly one record
//    kind=01,data=0xAB, out_valid next cycle.
//  2 Write addr=0x20,wdata=0x55,rdata=0x99 -> data=0x55; read&write together -> kind=11,data=wdata.
//  3 win_lo=0x100,win_hi=0x1FF; accesses at 0xFC,0x100,0x1FF,0x200 -> only 0x100,0x1FF recorded.
//  4 Stop mode, out_ready=0, 6 captures -> count=4, records 1-4 kept, dropped=2, overflow=0.
//  5 Wrap mode, same stimulus -> count=4, records 3-6 kept, overflow=1.
//    Capture+pop at full -> popped=old head, count=4.
//  6 Pulse held high across reset release -> no record. Reset/clear mid-drain -> out_valid=0 next cycle.
//    clear preserves ts.

Source files
------------

// File: rtl/mem_access_tracer_pkg.sv
// Shared definitions for the data-memory access tracer: access kind codes and
// the layout of a packed trace record {kind, addr, data, ts} (kind in the MSBs).
package mem_trace_pkg;

   localparam logic [1:0] KIND_RD = 2'b01;
   localparam logic [1:0] KIND_WR = 2'b10;
   localparam logic [1:0] KIND_RW = 2'b11;

   // Total width of one packed record.
   function automatic int rec_w(input int aw, input int dw, input int tw);
      return 2 + aw + dw + tw;
   endfunction

   // Field offsets (LSB positions) inside a packed record.
   function automatic int ts_lsb();
      return 0;
   endfunction

   function automatic int data_lsb(input int tw);
      return tw;
   endfunction

   function automatic int addr_lsb(input int dw, input int tw);
      return tw + dw;
   endfunction

   function automatic int kind_lsb(input int aw, input int dw, input int tw);
      return tw + dw + aw;
   endfunction

endpackage

// File: rtl/mem_access_tracer_ring_fifo.sv
// Ring buffer holding trace records. The count register runs 0..DEPTH, so full
// and empty stay distinct. When overwrite is set, a push into a full buffer
// replaces the oldest entry instead of being refused. The head entry is read
// combinationally.
module trace_ring_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     overwrite,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;
   logic             push_acc;
   logic             rd_adv;

   // Decide which operations actually happen this cycle. A push into a full
   // buffer is accepted if a pop frees the slot or overwrite is allowed; an
   // overwrite without a pop advances the read pointer past the lost entry.
   always_comb begin
      do_pop   = pop & ~empty;
      push_acc = push & (~full | do_pop | overwrite);
      rd_adv   = do_pop | (push_acc & full & ~do_pop);
   end

   // Pointer and occupancy state.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_adv)   rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_acc) - CNT_W'(rd_adv);
      end
   end

   // Record storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_acc) mem[wr_ptr] <= din;
   end

   // Status flags and combinational head read.
   always_comb begin
      empty = (count == '0);
      full  = (count == CNT_W'(DEPTH));
      dout  = mem[rd_ptr];
   end

endmodule

// File: rtl/mem_access_tracer.sv
// Data-memory access tracer: detects rising edges of the access strobe, filters
// by address window and pushes {kind, addr, data, ts} records into a ring
// buffer drained over a valid/ready port.
// Handshake: out_valid is high whenever a record is held; out_* show the head
// record and stay stable while out_valid & ~out_ready; the head is consumed on
// the rising clock edge where out_valid & out_ready are both high.
module mem_access_tracer
   import mem_trace_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   parameter int DROP_W = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       addr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic [DATA_W-1:0]       rdata,
   input  logic                    read,
   input  logic                    write,
   input  logic                    pulse,
   input  logic                    enable,
   input  logic                    wrap_mode,
   input  logic                    clear,
   input  logic [ADDR_W-1:0]       win_lo,
   input  logic [ADDR_W-1:0]       win_hi,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_kind,
   output logic [ADDR_W-1:0]       out_addr,
   output logic [DATA_W-1:0]       out_data,
   output logic [TS_W-1:0]         out_ts,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [DROP_W-1:0]       dropped
);

   localparam int REC_W  = rec_w(ADDR_W, DATA_W, TS_W);
   localparam int TS_L   = ts_lsb();
   localparam int DATA_L = data_lsb(TS_W);
   localparam int ADDR_L = addr_lsb(DATA_W, TS_W);
   localparam int KIND_L = kind_lsb(ADDR_W, DATA_W, TS_W);

   logic              pulse_q;
   logic              ev;
   logic              in_win;
   logic              capture;
   logic              pop;
   logic              flush;
   logic [TS_W-1:0]   ts;
   logic [1:0]        kind;
   logic [DATA_W-1:0] data_sel;
   logic [REC_W-1:0]  rec_in;
   logic [REC_W-1:0]  rec_out;
   logic              fifo_empty;
   logic              fifo_full;

   // Free-running timestamp; only reset clears it, clear leaves it running.
   always_ff @(posedge clk) begin
      if (reset) ts <= '0;
      else       ts <= ts + 1'b1;
   end

   // Strobe history; reset value 1 so a strobe held high across reset never captures.
   always_ff @(posedge clk) begin
      if (reset) pulse_q <= 1'b1;
      else       pulse_q <= pulse;
   end

   // Edge detect, address filter and record assembly from the bus in the edge cycle.
   always_comb begin
      ev       = pulse & ~pulse_q;
      in_win   = (addr >= win_lo) && (addr <= win_hi);
      capture  = ev & enable & (read | write) & in_win;
      kind     = {write, read};
      data_sel = write ? wdata : rdata;
      rec_in   = {kind, addr, data_sel, ts};
      pop      = ~fifo_empty & out_ready;
      flush    = reset | clear;
   end

   trace_ring_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (flush),
      .push      (capture),
      .pop       (pop),
      .overwrite (wrap_mode),
      .din       (rec_in),
      .dout      (rec_out),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (count)
   );

   // Loss accounting at full: stop mode counts refused records, wrap mode flags an overwrite.
   always_ff @(posedge clk) begin
      if (flush) begin
         overflow <= 1'b0;
         dropped  <= '0;
      end else if (capture & fifo_full & ~pop) begin
         if (wrap_mode)      overflow <= 1'b1;
         else if (~&dropped) dropped  <= dropped + 1'b1;
      end
   end

   // Head record fields, forced to zero while the buffer is empty.
   always_comb begin
      out_valid = ~fifo_empty;
      out_kind  = '0;
      out_addr  = '0;
      out_data  = '0;
      out_ts    = '0;
      if (!fifo_empty) begin
         out_kind = rec_out[KIND_L +: 2];
         out_addr = rec_out[ADDR_L +: ADDR_W];
         out_data = rec_out[DATA_L +: DATA_W];
         out_ts   = rec_out[TS_L +: TS_W];
      end
   end

endmodule
